// File: rtl/counter_prog_pkg.sv
// Shared types and helpers for the programmable period counter.
package counter_prog_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Up-counting runs restart from zero; down-counting runs restart from the period.
  function automatic logic [255:0] reload_value(input logic down, input logic [255:0] per);
    return down ? per : '0;
  endfunction

endpackage

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset to zero.
module flopenr #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)   q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/counter_prog.sv
// Programmable up/down counter with oneshot/periodic modes and a shadowed period register.
module counter_prog
  import counter_prog_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic             down,
  input  logic [WIDTH-1:0] period,
  input  logic             period_wr,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             oneshot_q, oneshot_d;
  logic             down_q, down_d;
  logic [WIDTH-1:0] count_d;
  logic             count_en;
  logic [WIDTH-1:0] next_period;
  logic [WIDTH-1:0] terminal;
  logic [255:0]     reload_wide;

  flopenr #(.WIDTH(WIDTH)) u_count (
    .clk   (clk),
    .reset (reset),
    .en    (count_en),
    .d     (count_d),
    .q     (count)
  );

  // Period that takes effect at the next load: a same-cycle write beats the shadow.
  always_comb begin
    next_period = period_q;
    if (period_wr)      next_period = period;
    else if (pending_q) next_period = shadow_q;
  end

  assign terminal = down_q ? '0 : period_q;
  assign tick     = (state_q == ST_RUN) && en && (count == terminal);
  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);

  always_comb begin
    reload_wide = reload_value(down, 256'(next_period));
    if (state_q == ST_RUN && !start) reload_wide = reload_value(down_q, 256'(next_period));
  end

  always_comb begin
    state_d   = state_q;
    period_d  = period_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    oneshot_d = oneshot_q;
    down_d    = down_q;
    count_d   = count;
    count_en  = 1'b0;

    if (period_wr) begin
      if (state_q == ST_RUN) begin
        shadow_d  = period;
        pending_d = 1'b1;
      end else begin
        period_d  = period;
      end
    end

    if (stop) begin
      state_d   = ST_IDLE;
      period_d  = next_period;
      pending_d = 1'b0;
      count_d   = '0;
      count_en  = 1'b1;
    end else if (start) begin
      state_d   = ST_RUN;
      oneshot_d = oneshot;
      down_d    = down;
      period_d  = next_period;
      pending_d = 1'b0;
      count_d   = reload_wide[WIDTH-1:0];
      count_en  = 1'b1;
    end else if (tick) begin
      period_d  = next_period;
      pending_d = 1'b0;
      if (oneshot_q) begin
        state_d = ST_DONE;
      end else begin
        count_d  = reload_wide[WIDTH-1:0];
        count_en = 1'b1;
      end
    end else if (state_q == ST_RUN && en) begin
      count_d  = down_q ? count - WIDTH'(1) : count + WIDTH'(1);
      count_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      oneshot_q <= 1'b0;
      down_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      oneshot_q <= oneshot_d;
      down_q    <= down_d;
    end
  end

endmodule

// File: tb/tb_counter_prog.sv
// Directed self-checking bench for counter_prog (WIDTH=8).
module tb_counter_prog;

  logic       clk = 1'b0;
  logic       reset, en, start, stop, oneshot, down, period_wr;
  logic [7:0] period;
  logic [7:0] count;
  logic       tick, running, done;

  int errors = 0;
  int checks = 0;

  counter_prog #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .start     (start),
    .stop      (stop),
    .oneshot   (oneshot),
    .down      (down),
    .period    (period),
    .period_wr (period_wr),
    .count     (count),
    .tick      (tick),
    .running   (running),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ct(input string tag, input int c, input int t);
    chk({tag, "_count"}, int'(count), c);
    chk({tag, "_tick"}, int'(tick), t);
  endtask

  initial begin
    reset = 1; en = 0; start = 0; stop = 0; oneshot = 0; down = 0;
    period_wr = 0; period = '0;
    step(); step();
    reset = 0;
    chk("rst_count", int'(count), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_tick", int'(tick), 0);

    // Periodic up, period 4
    period = 8'd4; period_wr = 1; step(); period_wr = 0;
    en = 1; start = 1; step(); start = 0;
    chk("p4_running", int'(running), 1);
    for (int i = 0; i < 12; i++) begin
      chk_ct("p4", i % 5, (i % 5 == 4) ? 1 : 0);
      step();
    end
    stop = 1; step(); stop = 0;
    chk("stop_running", int'(running), 0);
    chk("stop_count", int'(count), 0);

    // Oneshot down, period 3; mode inputs flipped mid-run must be ignored
    period = 8'd3; period_wr = 1; step(); period_wr = 0;
    oneshot = 1; down = 1; start = 1; step(); start = 0;
    oneshot = 0; down = 0;
    chk_ct("os3", 3, 0); step();
    chk_ct("os2", 2, 0); step();
    chk_ct("os1", 1, 0); step();
    chk_ct("os0", 0, 1); step();
    for (int i = 0; i < 11; i++) begin
      chk_ct("os_hold", 0, 0);
      chk("os_done", int'(done), 1);
      chk("os_running", int'(running), 0);
      step();
    end

    // Periodic up, period 9 with shadow write of 2 at count 4
    period = 8'd9; period_wr = 1; step(); period_wr = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) begin
      chk_ct("p9_a", i, 0); step();
    end
    chk_ct("p9_wr", 4, 0);
    period = 8'd2; period_wr = 1; step(); period_wr = 0;
    for (int i = 5; i < 9; i++) begin
      chk_ct("p9_b", i, 0); step();
    end
    chk_ct("p9_term", 9, 1); step();
    for (int r = 0; r < 2; r++) begin
      chk_ct("p2_0", 0, 0); step();
      chk_ct("p2_1", 1, 0); step();
      chk_ct("p2_2", 2, 1);
      if (r == 1) begin period = 8'd5; period_wr = 1; end
      step(); period_wr = 0;
    end
    for (int i = 0; i < 6; i++) begin
      chk_ct("p5", i, (i == 5) ? 1 : 0); step();
    end
    chk_ct("p5_wrap", 0, 0);

    // en toggling 1,0,0,1 at terminal, period 2
    stop = 1; step(); stop = 0;
    period = 8'd2; period_wr = 1; step(); period_wr = 0;
    start = 1; step(); start = 0;
    chk_ct("en_0", 0, 0); step();
    chk_ct("en_1", 1, 0); step();
    chk_ct("en_2", 2, 1);
    en = 0; #1;
    chk_ct("en_off_a", 2, 0); step();
    chk_ct("en_off_b", 2, 0); step();
    en = 1; #1;
    chk_ct("en_on", 2, 1); step();
    chk_ct("en_wrap", 0, 0);

    // Periodic down, period 2
    down = 1; start = 1; step(); start = 0; down = 0;
    chk_ct("dn_2", 2, 0); step();
    chk_ct("dn_1", 1, 0); step();
    chk_ct("dn_0", 0, 1); step();
    chk_ct("dn_rl", 2, 0);

    // start and stop together
    start = 1; stop = 1; step(); start = 0; stop = 0;
    chk("ss_running", int'(running), 0);
    chk("ss_count", int'(count), 0);

    // Reset mid-run with a pending shadow write
    start = 1; step(); start = 0;
    period = 8'd7; period_wr = 1; step(); period_wr = 0;
    chk("pend_count", int'(count), 1);
    reset = 1; step(); reset = 0;
    chk("mrst_count", int'(count), 0);
    chk("mrst_running", int'(running), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_tick", int'(tick), 0);

    // Period 0 (active period cleared by reset): tick every enabled cycle
    start = 1; step(); start = 0;
    for (int i = 0; i < 4; i++) begin
      chk_ct("p0", 0, 1); step();
    end

    // Period 255: full 256-cycle period
    stop = 1; step(); stop = 0;
    period = 8'd255; period_wr = 1; step(); period_wr = 0;
    start = 1; step(); start = 0;
    for (int i = 0; i < 300; i++) begin
      chk_ct("p255", i % 256, (i % 256 == 255) ? 1 : 0); step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
